// File: rtl/kt_seq_pkg.sv
// Shared types and constants for the Knight's Tour host-side command sequencer.
package kt_seq_pkg;

   typedef enum logic [1:0] {StIdle, StLoad, StWaitSnt, StWaitResp} seq_state_t;

   typedef enum logic [1:0] {
      ErrNone    = 2'd0,
      ErrBadResp = 2'd1,
      ErrTimeout = 2'd2
   } seq_err_t;

   localparam logic [7:0]  KT_ACK   = 8'hA5;
   localparam logic [15:0] CMD_CAL  = 16'h2000;
   localparam logic [3:0]  CMD_MOVE = 4'h4;

   function automatic logic [15:0] mk_move(input logic [11:0] arg);
      return {CMD_MOVE, arg};
   endfunction

endpackage

// File: rtl/kt_cmd_sequencer_if.sv
// Command/response handshake between the sequencer and RemoteComm.
interface kt_cmd_sequencer_if;
   logic        snd_cmd;
   logic [15:0] cmd;
   logic        cmd_snt;
   logic        resp_rdy;
   logic [7:0]  resp;

   modport master (output snd_cmd, cmd, input cmd_snt, resp_rdy, resp);
   modport slave  (input snd_cmd, cmd, output cmd_snt, resp_rdy, resp);
endinterface

// File: rtl/kt_cmd_fifo.sv
// Synchronous FIFO holding queued tour commands; extra pointer bit separates full from empty.
module kt_cmd_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             wr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             rd,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW     = $clog2(DEPTH);
   localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

   logic [AW:0]      wptr_q, rptr_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_rd, do_wr;

   assign empty = (wptr_q == rptr_q);
   assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign do_rd = rd && !empty;
   // A simultaneous pop frees the slot, so a write to a full FIFO still lands.
   assign do_wr = wr && (!full || do_rd);
   assign rdata = mem_q[rptr_q[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else if (flush) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (do_wr) wptr_q <= wptr_q + PtrOne;
         if (do_rd) rptr_q <= rptr_q + PtrOne;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr && !flush) mem_q[wptr_q[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/kt_cmd_sequencer.sv
// Issues queued tour commands to RemoteComm one at a time, waiting for an ACK between each.
module kt_cmd_sequencer
   import kt_seq_pkg::*;
#(
   parameter int unsigned DEPTH   = 8,
   parameter logic [23:0] TIMEOUT = 24'd1_000_000,
   parameter logic [7:0]  ACK     = KT_ACK
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      wr_cmd,
   input  logic [15:0]               cmd_in,
   input  logic                      start,
   input  logic                      abort,
   kt_cmd_sequencer_if.master        rc,
   output logic                      full,
   output logic                      empty,
   output logic                      ovfl,
   output logic                      busy,
   output logic                      done,
   output logic                      err,
   output logic [1:0]                err_code,
   output logic [7:0]                cmds_done
);

   seq_state_t  state_q, state_d;
   seq_err_t    err_code_q, err_code_d;
   logic [15:0] cmd_q, cmd_d, fifo_rdata;
   logic [23:0] cnt_q, cnt_d;
   logic [7:0]  cmds_q, cmds_d;
   logic        snd_q, snd_d, done_q, done_d, err_q, err_d, ovfl_q, ovfl_d;
   logic        pop;

   assign pop = (state_q == StLoad) && !abort;

   kt_cmd_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (16)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (abort),
      .wr    (wr_cmd),
      .wdata (cmd_in),
      .rd    (pop),
      .rdata (fifo_rdata),
      .full  (full),
      .empty (empty)
   );

   always_comb begin
      state_d    = state_q;
      cmd_d      = cmd_q;
      snd_d      = 1'b0;
      done_d     = 1'b0;
      err_d      = err_q;
      err_code_d = err_code_q;
      cnt_d      = cnt_q;
      cmds_d     = cmds_q;
      ovfl_d     = ovfl_q | (wr_cmd & full & ~pop);

      if (abort) begin
         state_d = StIdle;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  err_d      = 1'b0;
                  err_code_d = ErrNone;
                  ovfl_d     = 1'b0;
                  cmds_d     = '0;
                  if (empty) done_d = 1'b1;
                  else       state_d = StLoad;
               end
            end
            StLoad: begin
               cmd_d   = fifo_rdata;
               snd_d   = 1'b1;
               cnt_d   = '0;
               state_d = StWaitSnt;
            end
            StWaitSnt, StWaitResp: begin
               cnt_d = cnt_q + 24'd1;
               if (state_q == StWaitSnt && rc.cmd_snt) state_d = StWaitResp;
               // An early response (before or with cmd_snt) is still the answer to this command.
               if (rc.resp_rdy) begin
                  if (rc.resp == ACK) begin
                     if (cmds_q != 8'hFF) cmds_d = cmds_q + 8'd1;
                     if (empty) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                     end else begin
                        state_d = StLoad;
                     end
                  end else begin
                     err_d      = 1'b1;
                     err_code_d = ErrBadResp;
                     state_d    = StIdle;
                  end
               end else if (cnt_q == TIMEOUT - 24'd1) begin
                  err_d      = 1'b1;
                  err_code_d = ErrTimeout;
                  state_d    = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         cmd_q      <= '0;
         snd_q      <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         err_code_q <= ErrNone;
         cnt_q      <= '0;
         cmds_q     <= '0;
         ovfl_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cmd_q      <= cmd_d;
         snd_q      <= snd_d;
         done_q     <= done_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
         cnt_q      <= cnt_d;
         cmds_q     <= cmds_d;
         ovfl_q     <= ovfl_d;
      end
   end

   assign rc.snd_cmd = snd_q;
   assign rc.cmd     = cmd_q;
   assign busy       = (state_q != StIdle);
   assign done       = done_q;
   assign err        = err_q;
   assign err_code   = err_code_q;
   assign cmds_done  = cmds_q;
   assign ovfl       = ovfl_q;

endmodule
